// File: rtl/hpm_event_collector_if.sv
// Event-count bundle between the core pipeline sources and the HPM collector.
// The master drives per-cycle counts and controls; the slave returns pulses and status.
interface hpm_event_collector_if #(
  parameter int unsigned HPM_NUM_EVENTS = 28,
  parameter int unsigned CNT_W          = 2
);
  logic [HPM_NUM_EVENTS*CNT_W-1:0] evt_cnt_i;
  logic                            flush_i;
  logic                            drop_clr_i;
  logic [HPM_NUM_EVENTS:1]         events_o;
  logic [HPM_NUM_EVENTS:1]         evt_drop_o;
  logic                            pend_busy_o;

  modport master (
    output evt_cnt_i,
    output flush_i,
    output drop_clr_i,
    input  events_o,
    input  evt_drop_o,
    input  pend_busy_o
  );

  modport slave (
    input  evt_cnt_i,
    input  flush_i,
    input  drop_clr_i,
    output events_o,
    output evt_drop_o,
    output pend_busy_o
  );
endinterface

// File: rtl/hpm_event_collector.sv
// Accumulates multi-count event reports and drains them as one pulse per cycle
// per event toward the HPM counter block, flagging counts lost to saturation.
module hpm_event_collector #(
  parameter int unsigned HPM_NUM_EVENTS = 28,
  parameter int unsigned CNT_W          = 2,
  parameter int unsigned PEND_W         = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  hpm_event_collector_if.slave  bus
);

  localparam int unsigned N = HPM_NUM_EVENTS;

  localparam logic [PEND_W:0] PEND_MAX =
    {1'b0, {PEND_W{1'b1}}};
  localparam logic [PEND_W:0] ONE =
    {{PEND_W{1'b0}}, 1'b1};

  // The PEND_W+1 sum is only overflow-free while counts fit in the pending width.
  if (CNT_W > PEND_W) begin : g_bad_width
    $error("hpm_event_collector: CNT_W must not exceed PEND_W");
  end

  logic [N:1] events_d;
  logic [N:1] events_q;
  logic [N:1] drop_set;
  logic [N:1] drop_d;
  logic [N:1] drop_q;
  logic [N:1] pend_nz;

  for (genvar j = 1; j <= N; j++) begin : g_evt
    logic [CNT_W-1:0]  cnt;
    logic [PEND_W:0]   total;
    logic [PEND_W:0]   rem;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              ev_d;
    logic              set_d;

    assign cnt = bus.evt_cnt_i[(j-1)*CNT_W +: CNT_W];
    assign total = {1'b0, pend_q} + (PEND_W+1)'(cnt);

    always_comb begin
      rem    = '0;
      ev_d   = 1'b0;
      set_d  = 1'b0;
      pend_d = '0;
      if (!bus.flush_i) begin
        if (total != '0) begin
          ev_d = 1'b1;
          rem  = total - ONE;
        end
        if (rem > PEND_MAX) begin
          pend_d = PEND_MAX[PEND_W-1:0];
          set_d  = 1'b1;
        end else begin
          pend_d = rem[PEND_W-1:0];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        pend_q <= '0;
      end else begin
        pend_q <= pend_d;
      end
    end

    assign events_d[j] = ev_d;
    assign drop_set[j] = set_d;
    assign pend_nz[j]  = |pend_q;
  end

  // A saturation in the same cycle as a clear keeps the flag set.
  assign drop_d = (drop_q & ~{N{bus.drop_clr_i}}) | drop_set;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      events_q <= '0;
      drop_q   <= '0;
    end else begin
      events_q <= events_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.events_o    = events_q;
  assign bus.evt_drop_o  = drop_q;
  assign bus.pend_busy_o = |pend_nz;

endmodule

// File: tb/tb_hpm_event_collector.sv
// Directed bench for hpm_event_collector: pulses, bursts, saturation,
// flush, drop-clear priority and asynchronous reset.
module tb_hpm_event_collector;

  localparam int unsigned N  = 28;
  localparam int unsigned CW = 2;
  localparam int unsigned PW = 4;

  logic clk_i;
  logic rstn_i;

  int total;
  int bad;

  hpm_event_collector_if #(
    .HPM_NUM_EVENTS(N),
    .CNT_W(CW)
  ) bus ();

  hpm_event_collector #(
    .HPM_NUM_EVENTS(N),
    .CNT_W(CW),
    .PEND_W(PW)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .bus(bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put(input int j, input int v);
    logic [CW-1:0] c;
    c = CW'(v);
    bus.evt_cnt_i[(j-1)*CW +: CW] = c;
  endtask

  task automatic idle();
    bus.evt_cnt_i  = '0;
    bus.flush_i    = 1'b0;
    bus.drop_clr_i = 1'b0;
  endtask

  logic [N:1] e;

  initial begin
    total  = 0;
    bad    = 0;
    rstn_i = 1'b0;
    idle();
    #3;
    chk("rst_ev", 32'(bus.events_o), 0);
    chk("rst_drop", 32'(bus.evt_drop_o), 0);
    chk("rst_busy", 32'(bus.pend_busy_o), 0);
    #10;
    rstn_i = 1'b1;
    tick();

    // single pulse on event 5
    put(5, 1);
    tick();
    idle();
    e = '0;
    e[5] = 1'b1;
    chk("t1_ev", 32'(bus.events_o), 32'(e));
    chk("t1_busy", 32'(bus.pend_busy_o), 0);
    tick();
    chk("t1_ev_off", 32'(bus.events_o), 0);

    // burst of 3 on event 1
    put(1, 3);
    tick();
    idle();
    chk("t2_ev_c1", 32'(bus.events_o[1]), 1);
    chk("t2_busy_c1", 32'(bus.pend_busy_o), 1);
    tick();
    chk("t2_ev_c2", 32'(bus.events_o[1]), 1);
    chk("t2_busy_c2", 32'(bus.pend_busy_o), 1);
    tick();
    chk("t2_ev_c3", 32'(bus.events_o[1]), 1);
    chk("t2_busy_c3", 32'(bus.pend_busy_o), 0);
    tick();
    chk("t2_ev_c4", 32'(bus.events_o[1]), 0);
    chk("t2_drop", 32'(bus.evt_drop_o), 0);

    // saturation on event 2: 3 per cycle for cycles 0..9
    for (int c = 1; c <= 27; c++) begin
      if (c <= 10) put(2, 3);
      else idle();
      tick();
      chk($sformatf("t3_ev_c%0d", c),
          32'(bus.events_o[2]), (c <= 25) ? 1 : 0);
      if (c == 7)
        chk("t3_drop_c7", 32'(bus.evt_drop_o[2]), 0);
      if (c == 8)
        chk("t3_drop_c8", 32'(bus.evt_drop_o[2]), 1);
    end
    idle();
    chk("t3_busy_end", 32'(bus.pend_busy_o), 0);

    // flush mid-drain on event 3
    put(3, 3);
    tick();
    chk("t4_ev_c1", 32'(bus.events_o[3]), 1);
    idle();
    bus.flush_i = 1'b1;
    put(3, 2);
    tick();
    idle();
    chk("t4_ev_c2", 32'(bus.events_o[3]), 0);
    chk("t4_busy_c2", 32'(bus.pend_busy_o), 0);
    chk("t4_drop_kept", 32'(bus.evt_drop_o[2]), 1);
    tick();
    chk("t4_ev_c3", 32'(bus.events_o), 0);

    // drop-clear priority on event 2 with pend at 15
    for (int c = 0; c < 10; c++) begin
      put(2, 3);
      tick();
    end
    put(2, 2);
    bus.drop_clr_i = 1'b1;
    tick();
    idle();
    chk("t5_set_wins", 32'(bus.evt_drop_o[2]), 1);
    bus.drop_clr_i = 1'b1;
    tick();
    idle();
    chk("t5_cleared", 32'(bus.evt_drop_o[2]), 0);
    for (int c = 0; c < 20; c++) tick();
    chk("t5_drained", 32'(bus.pend_busy_o), 0);
    chk("t5_ev_idle", 32'(bus.events_o), 0);

    // asynchronous reset mid-drain on event 4
    for (int c = 0; c < 5; c++) begin
      put(4, 3);
      tick();
    end
    idle();
    chk("t6_ev_pre", 32'(bus.events_o[4]), 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_ev", 32'(bus.events_o), 0);
    chk("t6_rst_drop", 32'(bus.evt_drop_o), 0);
    chk("t6_rst_busy", 32'(bus.pend_busy_o), 0);
    tick();
    #2;
    rstn_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("t6_post_c%0d", c),
          32'(bus.events_o), 0);
    end
    chk("t6_post_drop", 32'(bus.evt_drop_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpm_event_collector.md
Name: hpm_event_collector

Overview:
- Sits directly upstream of the HPM counter block; drives its events_i vector.
- Core pipeline sources report per-cycle event counts of 0..2^CNT_W-1, e.g. multiple commits or misses per cycle. The counter block consumes only one increment per event per cycle.
- This block accumulates multi-count reports in per-event pending counters and drains them as a registered 1-bit-per-cycle pulse stream, so no counts are lost short of saturation.
- Lost counts are flagged with sticky per-event drop bits.

Parameters:
HPM_NUM_EVENTS, 28, number of event lines; event index 1..HPM_NUM_EVENTS matches the counter block's event select encoding
CNT_W, 2, width of each per-event input count (max 3 per cycle at default)
PEND_W, 4, width of each per-event pending counter (max 15 at default)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- evt_cnt_i  in  HPM_NUM_EVENTS*CNT_W  packed per-cycle counts; event j at bits [(j-1)*CNT_W +: CNT_W]
- flush_i  in  1  discard all pending counts and this cycle's inputs
- drop_clr_i  in  1  clear all sticky drop flags
- events_o  out  [HPM_NUM_EVENTS:1]  registered 1-bit event pulses to the counter block
- evt_drop_o  out  [HPM_NUM_EVENTS:1]  sticky flag per event: counts were lost to saturation
- pend_busy_o  out  1  OR over all events of (pend_q != 0)

Behaviour:
- Reset: pend_q=0 for all events, events_o=0, evt_drop_o=0, pend_busy_o=0.
- Per event j, each cycle, unless flush_i:
  - total = pend_q[j] + cnt_j, computed PEND_W+1 bits wide.
  - If total != 0: events_d[j]=1 and rem = total-1.
  - Else: events_d[j]=0 and rem=0.
  - If rem > 2^PEND_W-1: pend_d[j] = 2^PEND_W-1 and drop_d[j]=1.
  - Else: pend_d[j] = rem.
- Latency: an input count of n≥1 arriving at cycle t, with pend_q=0, makes events_o[j] high for cycles t+1 .. t+n.
- Continuous drain: events_o[j] stays high every cycle while pending or incoming counts are nonzero. It never exceeds one pulse per cycle.
- flush_i=1:
  - pend_d=0 for all events and events_d=0.
  - evt_cnt_i in that cycle is ignored.
  - Drop flags are unchanged.
  - Result: events_o=0 on the next cycle.
- Drop flags:
  - Set by a saturation event; cleared by drop_clr_i.
  - If set and clear occur in the same cycle for the same event, set wins (flag=1).
  - A set is never caused during flush.
- pend_busy_o is combinational from pend_q only; it does not include the events_o register.
- Events are fully independent: no arbitration and no cross-event interaction.
- Reset asserted mid-drain: everything returns to reset values immediately (asynchronous); pending counts are lost and no drop flag is set.
- Width rule: the PEND_W+1-bit sum cannot overflow, because the max sum 2^PEND_W-1 + 2^CNT_W-1 < 2^(PEND_W+1) for CNT_W ≤ PEND_W. The implementation must reject CNT_W > PEND_W at elaboration with $error.

Test Plan:
1. Single pulse:
   - Stimulus: evt_cnt event 5 = 1 at cycle 0 only.
   - Required: events_o[5]=1 at cycle 1 only; pend_busy_o stays 0; all other events_o bits 0.
2. Burst:
   - Stimulus: event 1 = 3 at cycle 0 only.
   - Required: events_o[1]=1 cycles 1,2,3 then 0; pend_busy_o=1 cycles 1–2 (pend_q 2 then 1); evt_drop_o=0.
3. Saturation:
   - Stimulus: event 2 = 3 for cycles 0–9, defaults.
   - Pend sequence is 2,4,…,14, then sum 17 → rem 16 at cycle 7.
   - Required: evt_drop_o[2]=1 from cycle 8; pend clamps at 15; events_o[2] high cycles 1 through 25 inclusive (drain of 15 after cycle 9), then low.
4. Flush mid-drain:
   - Stimulus: event 3 = 3 at cycle 0; flush_i=1 at cycle 1 together with event 3 = 2.
   - Required: events_o[3]=1 cycle 1 only, 0 at cycle 2 onward; pend_busy_o=0 from cycle 2.
5. Drop clear priority:
   - Stimulus: with evt_drop_o[2]=1 and pend_q[2]=15, drive drop_clr_i=1 and event 2 = 2 in the same cycle.
   - Required: evt_drop_o[2] remains 1.
   - Then apply drop_clr_i alone with no input: evt_drop_o[2]=0 next cycle.
6. Reset mid-operation:
   - Stimulus: event 4 = 3 for 5 cycles, then assert rstn_i=0 asynchronously between clock edges.
   - Required: events_o, evt_drop_o and pend_busy_o go to 0 immediately.
   - After release with zero inputs: no pulses appear.
